// File: rtl/melody_player.sv
// melody_player: plays {dur,pitch} entries from a small song memory as a square-wave buzzer tone.
// Optional feature: define MELODY_LOOP_EN to add the loop input (restart at entry 0 instead of finishing).
module melody_player #(
  parameter int DEPTH       = 32,
  parameter int ADDR_W      = 5,
  parameter int TICK_CYCLES = 12_500_000
) (
  input  logic              clk_50mhz,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] song_last,
`ifdef MELODY_LOOP_EN
  input  logic              loop,
`endif
  input  logic              start,
  input  logic              stop,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              bp
);
  localparam int DW = $clog2(8 * TICK_CYCLES + 1);
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, FETCH, PLAY} state_t;
  state_t state, state_n;
  logic [7:0] mem [DEPTH];
  logic [7:0] ent;
  logic [ADDR_W-1:0] last_q, last_c;
  logic [DW-1:0] dur_cnt, dur_end;
  logic [17:0] tone_cnt, period;
  logic loop_on, play_end, song_end;
`ifdef MELODY_LOOP_EN
  assign loop_on = loop;
`else
  assign loop_on = 1'b0;
`endif
  assign busy     = state != IDLE;
  assign last_c   = {1'b0, song_last} >= DEPTH_W ? ADDR_W'(DEPTH - 1) : song_last;
  assign dur_end  = DW'((32'(ent[7:5]) + 32'd1) * 32'(TICK_CYCLES) - 32'd1);
  assign play_end = state == PLAY && dur_cnt == dur_end;
  assign song_end = cur_addr == last_q && !loop_on;
  // a rest has period 0, so the compare below is never true and bp stays low
  assign bp       = state == PLAY && tone_cnt < (period >> 1);
  always_comb begin
    case (ent[4:0])
      5'd1:    period = 18'd191130;
      5'd2:    period = 18'd170241;
      5'd3:    period = 18'd151698;
      5'd4:    period = 18'd143183;
      5'd5:    period = 18'd127550;
      5'd6:    period = 18'd113635;
      5'd7:    period = 18'd101234;
      5'd8:    period = 18'd95546;
      5'd9:    period = 18'd85134;
      5'd10:   period = 18'd75837;
      5'd11:   period = 18'd71581;
      5'd12:   period = 18'd63775;
      5'd13:   period = 18'd56817;
      5'd14:   period = 18'd50617;
      5'd15:   period = 18'd47823;
      5'd16:   period = 18'd42563;
      5'd17:   period = 18'd37921;
      5'd18:   period = 18'd35793;
      5'd19:   period = 18'd31887;
      5'd20:   period = 18'd28408;
      5'd21:   period = 18'd25309;
      default: period = '0;
    endcase
  end
  always_comb begin
    state_n = stop ? IDLE :
              state == IDLE  ? (start ? FETCH : IDLE) :
              state == FETCH ? PLAY :
              !play_end      ? PLAY :
              song_end       ? IDLE : FETCH;
  end
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      done     <= 1'b0;
      cur_addr <= '0;
      last_q   <= '0;
      ent      <= '0;
      dur_cnt  <= '0;
      tone_cnt <= '0;
    end else begin
      state <= state_n;
      done  <= play_end && song_end && !stop;
      if (state == IDLE && start && !stop) begin
        cur_addr <= '0;
        last_q   <= last_c;
      end else if (play_end && !stop && !song_end)
        cur_addr <= cur_addr == last_q ? '0 : cur_addr + ADDR_W'(1);
      if (state == FETCH)
        ent <= mem[cur_addr];
      dur_cnt  <= state == PLAY && !play_end ? dur_cnt + DW'(1) : '0;
      tone_cnt <= state != PLAY || tone_cnt == period - 18'd1 ? '0 : tone_cnt + 18'd1;
    end
  end
  // song memory has no reset so a song survives rst_n
  always_ff @(posedge clk_50mhz) begin
    if (wr_en && state == IDLE && {1'b0, wr_addr} < DEPTH_W)
      mem[wr_addr] <= wr_data;
  end
endmodule

// File: tb/tb_melody_player.sv
// tb_melody_player: directed checks of melody_player; a second long-tick instance measures a real tone period.
module tb_melody_player;
  logic clk_50mhz = 1'b0;
  logic rst_n = 1'b0;
  logic wr_en = 1'b0, start = 1'b0, stop = 1'b0;
  logic [4:0] wr_addr = '0, song_last = '0;
  logic [7:0] wr_data = '0;
  logic busy, done, bp;
  logic [4:0] cur_addr;
  logic l_wr_en = 1'b0, l_start = 1'b0, l_busy, l_done, l_bp;
  logic [4:0] l_cur_addr;
`ifdef MELODY_LOOP_EN
  logic loop = 1'b0;
`endif
  int n_chk = 0, n_fail = 0;
  int cb[32], cp[32];
  int nd, done_at, first_bp, busy0, hi, lo, k;
  always #5 clk_50mhz = ~clk_50mhz;

  melody_player #(.DEPTH(32), .ADDR_W(5), .TICK_CYCLES(100)) dut (
    .clk_50mhz(clk_50mhz), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .song_last(song_last),
`ifdef MELODY_LOOP_EN
    .loop(loop),
`endif
    .start(start), .stop(stop), .busy(busy), .done(done), .cur_addr(cur_addr), .bp(bp));

  melody_player #(.DEPTH(32), .ADDR_W(5), .TICK_CYCLES(30000)) dut_l (
    .clk_50mhz(clk_50mhz), .rst_n(rst_n), .wr_en(l_wr_en), .wr_addr(5'd0), .wr_data(8'h15),
    .song_last(5'd0),
`ifdef MELODY_LOOP_EN
    .loop(1'b0),
`endif
    .start(l_start), .stop(1'b0), .busy(l_busy), .done(l_done), .cur_addr(l_cur_addr), .bp(l_bp));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk_50mhz);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk_50mhz);
    wr_en = 1'b0;
  endtask

  task automatic go(input logic [4:0] last);
    @(negedge clk_50mhz);
    song_last = last; start = 1'b1;
    @(negedge clk_50mhz);
    start = 1'b0;
  endtask

  // samples once per negedge until busy drops; poke injects a start (with song_last=0) mid-song
  task automatic run(input int max, input int poke);
    for (int a = 0; a < 32; a++) begin cb[a] = 0; cp[a] = 0; end
    nd = 0; done_at = -1; first_bp = -1; busy0 = int'(busy);
    for (int i = 0; i < max; i++) begin
      if (i == poke) begin start = 1'b1; song_last = 5'd0; end
      else if (i == poke + 1) start = 1'b0;
      if (done) begin nd++; done_at = i; end
      if (busy) begin
        cb[cur_addr]++;
        if (bp) cp[cur_addr]++;
        if (bp && first_bp < 0) first_bp = i;
      end
      if (!busy) return;
      @(negedge clk_50mhz);
    end
    check("run_timeout", busy, 0);
  endtask

  task automatic check_song2(input string tag);
    check({tag, "_len0"}, cb[0], 201);
    check({tag, "_len1"}, cb[1], 101);
    check({tag, "_len2"}, cb[2], 301);
    check({tag, "_bp0"}, cp[0], 200);
    check({tag, "_bp1"}, cp[1], 0);
    check({tag, "_bp2"}, cp[2], 300);
    check({tag, "_done"}, nd, 1);
  endtask

  initial begin
    #800_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk_50mhz);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bp", bp, 0);
    check("rst_addr", cur_addr, 0);
    rst_n = 1'b1;
    // single L1 note, dur 0
    wr(5'd0, 8'h01);
    go(5'd0);
    run(2000, -5);
    check("t1_busy_p1", busy0, 1);
    check("t1_first_bp", first_bp, 1);
    check("t1_done_at", done_at, 101);
    check("t1_len", cb[0], 101);
    check("t1_bp_hi", cp[0], 100);
    check("t1_ndone", nd, 1);
    @(negedge clk_50mhz);
    check("t1_done_1cyc", done, 0);
    // three-entry song: H7 dur1, rest dur0, M7 dur2
    wr(5'd0, 8'h35);
    wr(5'd1, 8'h00);
    wr(5'd2, 8'h4E);
    go(5'd2);
    run(2000, -5);
    check_song2("t2");
    // stop 50 cycles into the first PLAY
    go(5'd2);
    repeat (51) @(negedge clk_50mhz);
    check("t3_bp_before", bp, 1);
    stop = 1'b1;
    @(negedge clk_50mhz);
    stop = 1'b0;
    check("t3_busy", busy, 0);
    check("t3_bp", bp, 0);
    check("t3_done", done, 0);
    nd = 0;
    repeat (400) begin @(negedge clk_50mhz); if (done || busy) nd++; end
    check("t3_quiet", nd, 0);
    // simultaneous start and stop in IDLE
    @(negedge clk_50mhz);
    song_last = 5'd2; start = 1'b1; stop = 1'b1;
    @(negedge clk_50mhz);
    start = 1'b0; stop = 1'b0;
    check("t4_startstop", busy, 0);
    // writes during FETCH and PLAY must be dropped
    go(5'd2);
    wr_en = 1'b1; wr_addr = 5'd1; wr_data = 8'h55;
    @(negedge clk_50mhz);
    wr_addr = 5'd0; wr_data = 8'h00;
    @(negedge clk_50mhz);
    wr_en = 1'b0;
    run(2000, -5);
    check("t4_drain_done", nd, 1);
    go(5'd2);
    run(2000, -5);
    check_song2("t4");
    // start while busy (with a different song_last) is ignored
    go(5'd2);
    run(2000, 250);
    check_song2("t5");
    // async reset mid-song
    go(5'd2);
    repeat (350) @(negedge clk_50mhz);
    check("t6_addr_pre", cur_addr, 2);
    #1 rst_n = 1'b0;
    #1;
    check("t6_busy", busy, 0);
    check("t6_bp", bp, 0);
    check("t6_done", done, 0);
    check("t6_addr", cur_addr, 0);
    @(negedge clk_50mhz);
    rst_n = 1'b1;
    go(5'd2);
    run(2000, -5);
    check_song2("t6");
    // long-tick instance: full H7 period inside one 30000-cycle note
    @(negedge clk_50mhz);
    l_wr_en = 1'b1;
    @(negedge clk_50mhz);
    l_wr_en = 1'b0; l_start = 1'b1;
    @(negedge clk_50mhz);
    l_start = 1'b0;
    @(negedge clk_50mhz);
    hi = 0; lo = 0; k = 0;
    while (l_bp && hi < 40000) begin hi++; @(negedge clk_50mhz); end
    while (!l_bp && l_busy && lo < 40000) begin lo++; @(negedge clk_50mhz); end
    check("t7_h7_high", hi, 12654);
    check("t7_h7_low", lo, 12655);
    while (!l_done && k < 40000) begin k++; @(negedge clk_50mhz); end
    check("t7_rest_of_note", k, 4691);
`ifdef MELODY_LOOP_EN
    begin
      int wraps;
      logic [4:0] prev;
      loop = 1'b1;
      go(5'd1);
      nd = 0; wraps = 0; prev = cur_addr;
      repeat (1500) begin
        @(negedge clk_50mhz);
        if (done) nd++;
        if (prev == 5'd1 && cur_addr == 5'd0) wraps++;
        prev = cur_addr;
      end
      check("t8_wraps", wraps, 4);
      check("t8_no_done", nd, 0);
      loop = 1'b0;
      run(2000, -5);
      check("t8_done", nd, 1);
      check("t8_end_addr", cur_addr, 1);
    end
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/melody_player.md
MELODY_PLAYER -- requirements
Module: melody_player

Interface
REQ-001 SHALL provide parameter DEPTH, default 32, number of song memory entries.
REQ-002 SHALL provide parameter ADDR_W, default 5, address width; 2**ADDR_W >= DEPTH.
REQ-003 SHALL provide parameter TICK_CYCLES, default 12_500_000, clk_50mhz cycles per duration unit (250 ms).
REQ-004 clk_50mhz  input  1  system clock, 50 MHz.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 wr_en  input  1  song memory write strobe.
REQ-007 wr_addr  input  ADDR_W  song memory write address.
REQ-008 wr_data  input  8  entry {dur[7:5], pitch[4:0]}.
REQ-009 song_last  input  ADDR_W  index of final entry played.
REQ-010 start  input  1  one-cycle request to begin playback at entry 0.
REQ-011 stop  input  1  one-cycle request to abort playback.
REQ-012 busy  output  1  high while not IDLE.
REQ-013 done  output  1  one-cycle pulse on normal completion.
REQ-014 cur_addr  output  ADDR_W  entry currently fetched/playing.
REQ-015 bp  output  1  square-wave buzzer drive.

Function
REQ-016 States SHALL be IDLE, FETCH, PLAY; one-hot or binary is permitted.
REQ-017 IDLE->FETCH SHALL occur on start; cur_addr SHALL load 0; busy SHALL be high from the next cycle.
REQ-018 FETCH SHALL last exactly one cycle (synchronous memory read), then go to PLAY.
REQ-019 PLAY SHALL last (dur+1)*TICK_CYCLES cycles for the fetched entry, counted from its first PLAY cycle.
REQ-020 At the end of PLAY with cur_addr != song_last, cur_addr SHALL increment and the state SHALL return to FETCH.
REQ-021 At the end of PLAY with cur_addr == song_last, the state SHALL go to IDLE and done SHALL pulse for one cycle.
REQ-022 Pitch codes 1..21 SHALL map to period counts L1..H7: 191130, 170241, 151698, 143183, 127550, 113635, 101234, 95546, 85134, 75837, 71581, 63775, 56817, 50617, 47823, 42563, 37921, 35793, 31887, 28408, 25309.
REQ-023 Pitch code 0 and codes 22..31 SHALL be rests; bp SHALL be 0 for the whole entry.
REQ-024 The tone counter SHALL restart at 0 on the first PLAY cycle of every entry and wrap at period-1.
REQ-025 bp SHALL be 1 while tone counter < period>>1, else 0, giving a 50% duty cycle; the first PLAY cycle of a pitched entry SHALL drive bp=1.
REQ-026 bp SHALL be 0 in IDLE and FETCH.
REQ-027 Writes SHALL be accepted only in IDLE; wr_en while busy SHALL be ignored; wr_addr >= DEPTH SHALL be ignored.
REQ-028 start while busy SHALL be ignored.
REQ-029 stop in any state SHALL force IDLE on the next edge, with bp=0 and no done pulse.
REQ-030 If stop and start are both asserted in IDLE, stop SHALL win and the block SHALL remain IDLE.
REQ-031 song_last SHALL be sampled on start and held for the whole playback; a value >= DEPTH SHALL be clamped to DEPTH-1.
REQ-032 Duration and tone counters SHALL be wide enough for 8*TICK_CYCLES and 191130 respectively, with no overflow.

Reset
REQ-033 rst_n low SHALL asynchronously force IDLE, cur_addr=0, busy=0, done=0, bp=0, and clear all counters.
REQ-034 Song memory contents SHALL NOT be cleared by reset; reset mid-playback SHALL abort without a done pulse.

Configuration
REQ-035 With macro MELODY_LOOP_EN defined, input port loop (1 bit) SHALL exist; when loop=1 at the end of the song_last entry, cur_addr SHALL return to 0 via FETCH and no done pulse SHALL occur.
REQ-036 With MELODY_LOOP_EN undefined, the loop port SHALL be absent and playback SHALL always end per REQ-021.

Verification (TICK_CYCLES=100)
REQ-037 Write {0,1} at addr 0, song_last=0, start -> busy at +1, bp=1 at +2, bp period 191130; done pulses once exactly 100 PLAY cycles after the first PLAY cycle.
REQ-038 Entries {1,21},{0,0},{2,14}, song_last=2 -> PLAY lengths 200/100/300; bp silent during entry 1; H7 period 25309.
REQ-039 stop asserted 50 cycles into PLAY -> IDLE next cycle, bp=0, busy=0, no done pulse.
REQ-040 Simultaneous start and stop in IDLE -> remains IDLE; wr_en during PLAY -> memory unchanged on readback playback.
REQ-041 rst_n low mid-PLAY -> all outputs 0 immediately; the previously written song replays correctly after a subsequent start.
REQ-042 (MELODY_LOOP_EN) loop=1, song_last=1 -> cur_addr sequence 0,1,0,1...; no done pulse; clearing loop ends the song at index 1 with a done pulse.
